// File: rtl/nco_sine_gen_if.sv
// nco_sine_gen_if
//   Configuration bus and sample stream of the nco_sine_gen NCO.
//   Ports (signals):
//     cfg_wr     : write cfg_ftw/cfg_poff/cfg_amp into shadow regs of cfg_ch
//     cfg_ch     : target channel of a shadow write
//     cfg_ftw    : frequency tuning word
//     cfg_poff   : phase offset
//     cfg_amp    : unsigned amplitude, 2^(OUT_W-1) = unity
//     cfg_commit : copy every shadow register into the active set
//     out_valid  : sine_out carries a valid sample set
//     out_ready  : consumer accepts the current sample set
//     sine_out   : packed signed samples, channel c at [c*OUT_W +: OUT_W]
//   Modports: master = configuration source / sample consumer,
//             slave  = the NCO itself.
interface nco_sine_gen_if #(
  parameter int NUM_CH  = 2,
  parameter int OUT_W   = 16,
  parameter int PHASE_W = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                      cfg_wr;
  logic [CH_W-1:0]           cfg_ch;
  logic [PHASE_W-1:0]        cfg_ftw;
  logic [PHASE_W-1:0]        cfg_poff;
  logic [OUT_W-1:0]          cfg_amp;
  logic                      cfg_commit;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_CH*OUT_W-1:0]   sine_out;

  modport master (
    output cfg_wr, cfg_ch, cfg_ftw, cfg_poff, cfg_amp, cfg_commit, out_ready,
    input  out_valid, sine_out
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_ftw, cfg_poff, cfg_amp, cfg_commit, out_ready,
    output out_valid, sine_out
  );
endinterface

// File: rtl/nco_sine_gen.sv
// nco_sine_gen
//   Multi-channel programmable NCO. Each channel owns a phase accumulator and
//   an active FTW / phase offset / amplitude set loaded from shadow registers
//   on commit. A shared elaboration-time sine table feeds a three-register
//   pipeline (address, table read, amplitude scale) with valid/ready output.
//   Ports:
//     clk    : clock for all logic
//     reset  : synchronous active-high reset
//     enable : insert a new sample set and advance accumulators on a move
//     sync   : zero every accumulator (wins over the increment)
//     bus    : nco_sine_gen_if.slave (configuration port + sample stream)
module nco_sine_gen #(
  parameter int OUT_W   = 16,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int NUM_CH  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          sync,
  nco_sine_gen_if.slave bus
);
  localparam int  CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int  LUT_N  = 1 << LUT_AW;
  localparam int  PROD_W = 2 * OUT_W + 1;
  localparam real PI     = 3.14159265358979323846;
  localparam real LUT_A  = real'((32'sd1 <<< (OUT_W - 1)) - 32'sd1);
  localparam logic [OUT_W-1:0] AMP_UNITY = {1'b1, {(OUT_W-1){1'b0}}};

  // Full-wave sine table, fixed at elaboration ($rtoi truncates toward zero).
  logic signed [OUT_W-1:0] lut_s [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam int ENTRY = $rtoi(LUT_A * $sin(2.0 * PI * gi / LUT_N));
    assign lut_s[gi] = OUT_W'(ENTRY);
  end

  logic [PHASE_W-1:0]      acc_q     [NUM_CH];
  logic [PHASE_W-1:0]      acc_d     [NUM_CH];
  logic [PHASE_W-1:0]      ftw_sh_q  [NUM_CH];
  logic [PHASE_W-1:0]      poff_sh_q [NUM_CH];
  logic [OUT_W-1:0]        amp_sh_q  [NUM_CH];
  logic [PHASE_W-1:0]      ftw_q     [NUM_CH];
  logic [PHASE_W-1:0]      poff_q    [NUM_CH];
  logic [OUT_W-1:0]        amp_q     [NUM_CH];
  logic [LUT_AW-1:0]       addr_q    [NUM_CH];
  logic [LUT_AW-1:0]       addr_d    [NUM_CH];
  logic signed [OUT_W-1:0] lut_q     [NUM_CH];
  logic [OUT_W-1:0]        amp_eff_s [NUM_CH];
  logic signed [PROD_W-1:0] prod_s   [NUM_CH];
  logic                    v0_q;
  logic                    v1_q;
  logic                    out_valid_q;
  logic [NUM_CH*OUT_W-1:0] sine_q;
  logic [NUM_CH*OUT_W-1:0] sine_d;
  logic                    move_s;

  // Pipeline advance condition, accumulator next state, address and product.
  always_comb begin
    move_s = bus.out_ready || !out_valid_q;
    sine_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      // Top LUT_AW bits of (acc + poff), modulo 2^PHASE_W.
      addr_d[c] = LUT_AW'((acc_q[c] + poff_q[c]) >> (PHASE_W - LUT_AW));
      if (sync) begin
        acc_d[c] = '0;
      end else if (move_s && enable) begin
        acc_d[c] = acc_q[c] + ftw_q[c];
      end else begin
        acc_d[c] = acc_q[c];
      end
      // Above-unity amplitudes are clamped so the product cannot overflow.
      if (amp_q[c] > AMP_UNITY) begin
        amp_eff_s[c] = AMP_UNITY;
      end else begin
        amp_eff_s[c] = amp_q[c];
      end
      prod_s[c] = $signed({{(OUT_W+1){lut_q[c][OUT_W-1]}}, lut_q[c]}) *
                  $signed({{OUT_W{1'b0}}, amp_eff_s[c]});
      sine_d[c*OUT_W +: OUT_W] = OUT_W'(prod_s[c] >>> (OUT_W - 1));
    end
  end

  // Accumulators, shadow/active configuration and the three pipeline stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]     <= '0;
        ftw_sh_q[c]  <= '0;
        poff_sh_q[c] <= '0;
        amp_sh_q[c]  <= AMP_UNITY;
        ftw_q[c]     <= '0;
        poff_q[c]    <= '0;
        amp_q[c]     <= AMP_UNITY;
        addr_q[c]    <= '0;
        lut_q[c]     <= '0;
      end
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sine_q      <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
        // Commit takes the pre-write shadow; a same-cycle write waits.
        if (bus.cfg_commit) begin
          ftw_q[c]  <= ftw_sh_q[c];
          poff_q[c] <= poff_sh_q[c];
          amp_q[c]  <= amp_sh_q[c];
        end
        // Channel numbers >= NUM_CH never match and are dropped.
        if (bus.cfg_wr && (bus.cfg_ch == CH_W'(c))) begin
          ftw_sh_q[c]  <= bus.cfg_ftw;
          poff_sh_q[c] <= bus.cfg_poff;
          amp_sh_q[c]  <= bus.cfg_amp;
        end
      end
      if (move_s) begin
        v0_q        <= enable;
        v1_q        <= v0_q;
        out_valid_q <= v1_q;
        sine_q      <= sine_d;
        for (int c = 0; c < NUM_CH; c++) begin
          if (enable) begin
            addr_q[c] <= addr_d[c];
          end else begin
            addr_q[c] <= addr_q[c];
          end
          lut_q[c] <= lut_s[addr_q[c]];
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sine_out  = sine_q;
endmodule

// File: tb/tb_nco_sine_gen.sv
`timescale 1ns/1ps
module tb_nco_sine_gen;
  localparam int  OUT_W   = 16;
  localparam int  PHASE_W = 32;
  localparam int  LUT_AW  = 10;
  localparam int  NUM_CH  = 2;
  localparam int  SW      = NUM_CH * OUT_W;
  localparam int  UNITY   = 32768;
  localparam real PI      = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic sync;

  nco_sine_gen_if #(.NUM_CH(NUM_CH), .OUT_W(OUT_W), .PHASE_W(PHASE_W)) bus ();

  nco_sine_gen #(
    .OUT_W(OUT_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .NUM_CH(NUM_CH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit [31:0]   m_acc [NUM_CH];
  bit [31:0]   m_ftw [NUM_CH];
  bit [31:0]   m_poff[NUM_CH];
  int          m_amp [NUM_CH];
  bit [31:0]   s_ftw [NUM_CH];
  bit [31:0]   s_poff[NUM_CH];
  int          s_amp [NUM_CH];
  bit          m_slot[3];          // valid flags of the three stages; [2] is the output
  bit          rst_chk = 1'b0;
  bit [SW-1:0] sb_q[$];            // expected sample sets, oldest first
  bit [SW-1:0] log_q[$];           // accepted sample sets
  bit          stall_prev = 1'b0;
  logic [SW-1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int lut_val(input int i);
    return $rtoi(32767.0 * $sin(2.0 * PI * i / 1024.0));
  endfunction

  function automatic bit [SW-1:0] model_sample();
    bit [SW-1:0] r;
    bit [31:0]   ph;
    int          a;
    longint      p;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ph = m_acc[c] + m_poff[c];
      a  = (m_amp[c] > UNITY) ? UNITY : m_amp[c];
      p  = longint'(lut_val(int'(ph >> 22))) * longint'(a);
      p  = p >>> 15;
      r[c*OUT_W +: OUT_W] = p[OUT_W-1:0];
    end
    return r;
  endfunction

  // Applies the spec's rules for the coming clock edge using the driven inputs.
  task automatic model_edge();
    bit mv;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_acc[c] = 0; m_ftw[c] = 0; m_poff[c] = 0; s_ftw[c] = 0; s_poff[c] = 0;
        m_amp[c] = UNITY; s_amp[c] = UNITY;
      end
      for (int k = 0; k < 3; k++) m_slot[k] = 1'b0;
      sb_q.delete();
      rst_chk = 1'b1;
    end else begin
      mv = bus.out_ready || !m_slot[2];
      if (mv) begin
        if (enable) begin
          sb_q.push_back(model_sample());
          for (int c = 0; c < NUM_CH; c++) m_acc[c] = m_acc[c] + m_ftw[c];
        end
        m_slot[2] = m_slot[1];
        m_slot[1] = m_slot[0];
        m_slot[0] = enable;
      end
      if (sync) for (int c = 0; c < NUM_CH; c++) m_acc[c] = 0;
      if (bus.cfg_commit) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_ftw[c] = s_ftw[c]; m_poff[c] = s_poff[c]; m_amp[c] = s_amp[c];
        end
      end
      if (bus.cfg_wr) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (int'(bus.cfg_ch) == c) begin
            s_ftw[c] = bus.cfg_ftw; s_poff[c] = bus.cfg_poff; s_amp[c] = int'(bus.cfg_amp);
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("out_valid", 64'(bus.out_valid), 64'(m_slot[2]));
    if (rst_chk) begin
      check("reset_sine_out", 64'(bus.sine_out), 64'd0);
      rst_chk = 1'b0;
    end
    sync = 1'b0;
    bus.cfg_wr = 1'b0;
    bus.cfg_commit = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input bit [31:0] ftw, input bit [31:0] poff, input int amp);
    bus.cfg_wr   = 1'b1;
    bus.cfg_ch   = 1'(ch);
    bus.cfg_ftw  = ftw;
    bus.cfg_poff = poff;
    bus.cfg_amp  = 16'(amp);
    tick();
  endtask

  task automatic commit(input bit with_sync);
    bus.cfg_commit = 1'b1;
    sync = with_sync;
    tick();
  endtask

  task automatic drain();
    enable = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic wait_samples(input string name, input int n);
    int guard = 0;
    while (log_q.size() < n && guard < 60) begin
      tick();
      guard++;
    end
    check_int(name, (log_q.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic log_chk(input string name, input int k, input int c, input int exp);
    if (k < log_q.size()) check_int(name, int'($signed(log_q[k][c*OUT_W +: OUT_W])), exp);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      if (stall_prev) begin
        check("stall_valid_hold", 64'(bus.out_valid), 64'd1);
        check("stall_sine_hold", 64'(bus.sine_out), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check_int("unexpected_sample", 1, 0);
        end else begin
          check("sample", 64'(bus.sine_out), 64'(sb_q.pop_front()));
        end
        log_q.push_back(bus.sine_out);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = bus.sine_out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ch;
    reset = 1'b1; enable = 1'b0; sync = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_ftw = '0; bus.cfg_poff = '0;
    bus.cfg_amp = '0; bus.cfg_commit = 1'b0; bus.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Quarter-rate on ch0 with default amplitude, plus first-valid latency.
    cfg_write(0, 32'h4000_0000, 32'h0, UNITY);
    commit(1'b0);
    log_q.delete();
    enable = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.out_valid && k < 10);
    check_int("first_valid_latency", k, 3);
    wait_samples("quarter_wait", 8);
    for (int i = 0; i < 8; i++) begin
      log_chk("quarter_ch0", i, 0, (i % 4 == 1) ? 32767 : ((i % 4 == 3) ? -32767 : 0));
    end

    // Backpressure for five cycles mid-stream.
    bus.out_ready = 1'b0;
    repeat (5) tick();
    bus.out_ready = 1'b1;
    repeat (10) tick();
    drain();

    // ch1 phase offset and half amplitude; ch0 keeps running in the model.
    cfg_write(1, 32'h4000_0000, 32'h4000_0000, 16384);
    commit(1'b0);
    log_q.delete();
    enable = 1'b1;
    wait_samples("poff_wait", 8);
    for (int i = 0; i < 8; i++) begin
      log_chk("poff_amp_ch1", i, 1, (i % 4 == 0) ? 16383 : ((i % 4 == 2) ? -16384 : 0));
    end
    drain();

    // Sync with commit; the write in the commit cycle stays in the shadow.
    cfg_write(0, 32'h2000_0000, 32'h0, UNITY);
    bus.cfg_wr = 1'b1; bus.cfg_ch = 1'b0; bus.cfg_ftw = 32'h1000_0000;
    bus.cfg_poff = 32'h0; bus.cfg_amp = 16'(UNITY);
    commit(1'b1);
    log_q.delete();
    enable = 1'b1;
    wait_samples("sync_wait", 3);
    log_chk("sync_first", 0, 0, 0);
    log_chk("sync_second", 1, 0, 23169);
    log_chk("sync_third", 2, 0, 32767);
    drain();
    commit(1'b1);
    log_q.delete();
    enable = 1'b1;
    wait_samples("held_wait", 2);
    log_chk("held_write_first", 0, 0, 0);
    log_chk("held_write_second", 1, 0, lut_val(64));
    drain();

    // Negative step wrap, with amp above unity clamped.
    cfg_write(0, 32'hFFC0_0000, 32'h0, 16'hFFFF);
    commit(1'b1);
    log_q.delete();
    enable = 1'b1;
    wait_samples("wrap_wait", 3);
    log_chk("wrap_0", 0, 0, lut_val(0));
    log_chk("wrap_1023", 1, 0, lut_val(1023));
    log_chk("wrap_1022", 2, 0, lut_val(1022));
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 99) begin
        drain();
        for (int c = 0; c < NUM_CH; c++) cfg_write(c, s_ftw[c], s_poff[c], $urandom_range(0, 65535));
        commit(1'b0);
      end else begin
        enable = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 15) == 0) begin
          ch = $urandom_range(0, NUM_CH - 1);
          bus.cfg_wr = 1'b1; bus.cfg_ch = 1'(ch); bus.cfg_ftw = $urandom;
          bus.cfg_poff = $urandom; bus.cfg_amp = 16'(s_amp[ch]);
        end
        bus.cfg_commit = ($urandom_range(0, 19) == 0);
        sync = ($urandom_range(0, 29) == 0);
        tick();
      end
    end
    drain();
    check_int("scoreboard_empty", sb_q.size(), 0);

    // Reset while stalled with a valid sample presented.
    enable = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    enable = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    cfg_write(0, 32'h4000_0000, 32'h0, UNITY);
    commit(1'b0);
    log_q.delete();
    enable = 1'b1;
    wait_samples("restart_wait", 4);
    for (int i = 0; i < 4; i++) begin
      log_chk("restart_ch0", i, 0, (i == 1) ? 32767 : ((i == 3) ? -32767 : 0));
    end
    drain();
    check_int("final_scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
